// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter for the single data-memory port: pipeline MEM stage (port 0) and debug/loader DMA (port 1).
// Latency: grant and memory strobe in the request cycle, response (rdata/ack/err) exactly one cycle later.
// Backpressure: a requester holds valid until ready; port 0 sees stall_o while it waits, port 1 may lock the grant.
module dmem_port_arbiter #(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 11,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              p0_valid_i,
    output logic              p0_ready_o,
    input  logic              p0_we_i,
    input  logic [3:0]        p0_be_i,
    input  logic [XLEN-1:0]   p0_addr_i,
    input  logic [XLEN-1:0]   p0_wdata_i,
    output logic              p0_rvalid_o,
    output logic [XLEN-1:0]   p0_rdata_o,
    output logic              p0_err_o,
    input  logic              p1_valid_i,
    output logic              p1_ready_o,
    input  logic              p1_we_i,
    input  logic [3:0]        p1_be_i,
    input  logic [XLEN-1:0]   p1_addr_i,
    input  logic [XLEN-1:0]   p1_wdata_i,
    output logic              p1_rvalid_o,
    output logic [XLEN-1:0]   p1_rdata_o,
    output logic              p1_err_o,
    input  logic              p1_lock_i,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic [XLEN-1:0]   mem_rdata_i
);
    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

    typedef enum logic {ST_ARB = 1'b0, ST_LOCK = 1'b1} state_t;

    state_t           state_q, state_d;
    logic             rr_last_q, rr_last_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic             resp_pend_q, resp_pend_d;
    logic             resp_owner_q, resp_owner_d;
    logic             resp_err_q, resp_err_d;
    logic             resp_rd_q, resp_rd_d;

    logic             gnt0, gnt1, gnt_any;
    logic             sel_we, sel_bad;
    logic [3:0]       sel_be;
    logic [XLEN-1:0]  sel_addr, sel_wdata;
    logic [CNT_W-1:0] cnt_inc, cnt_nxt;
    logic             force_rel;

    function automatic logic req_bad(input logic [3:0] be, input logic [XLEN-1:0] addr);
        logic be_ok;
        case (be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: be_ok = 1'b1;
            default:                   be_ok = 1'b0;
        endcase
        return !be_ok || (addr[1:0] != 2'b00) || ((addr >> (ADDR_W + 2)) != '0);
    endfunction

    // While locked, port 1 is held off once it has used its LOCK_MAX beats and port 0 is waiting.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rstn_i) begin
            case (state_q)
                ST_ARB: begin
                    if (p0_valid_i && p1_valid_i) begin
                        gnt0 = rr_last_q;
                        gnt1 = !rr_last_q;
                    end else begin
                        gnt0 = p0_valid_i;
                        gnt1 = p1_valid_i;
                    end
                end
                ST_LOCK: gnt1 = p1_valid_i && !((lock_cnt_q >= CNT_MAX) && p0_valid_i);
                default: ;
            endcase
        end
    end

    assign gnt_any   = gnt0 | gnt1;
    assign sel_we    = gnt1 ? p1_we_i    : p0_we_i;
    assign sel_be    = gnt1 ? p1_be_i    : p0_be_i;
    assign sel_addr  = gnt1 ? p1_addr_i  : p0_addr_i;
    assign sel_wdata = gnt1 ? p1_wdata_i : p0_wdata_i;
    assign sel_bad   = req_bad(sel_be, sel_addr);

    assign p0_ready_o  = gnt0;
    assign p1_ready_o  = gnt1;
    assign stall_o     = rstn_i & p0_valid_i & ~gnt0;

    assign mem_req_o   = gnt_any & ~sel_bad;
    assign mem_we_o    = mem_req_o & sel_we;
    assign mem_be_o    = mem_req_o ? sel_be : 4'b0000;
    assign mem_addr_o  = mem_req_o ? sel_addr[ADDR_W+1:2] : '0;
    assign mem_wdata_o = (mem_req_o && sel_we) ? sel_wdata : '0;

    assign cnt_inc   = (lock_cnt_q >= CNT_MAX) ? lock_cnt_q : lock_cnt_q + CNT_W'(1);
    assign cnt_nxt   = !gnt1 ? lock_cnt_q : ((state_q == ST_LOCK) ? cnt_inc : CNT_W'(1));
    assign force_rel = (cnt_nxt >= CNT_MAX) && p0_valid_i;

    always_comb begin
        state_d      = state_q;
        rr_last_d    = gnt_any ? gnt1 : rr_last_q;
        lock_cnt_d   = cnt_nxt;
        resp_pend_d  = gnt_any;
        resp_owner_d = gnt1;
        resp_err_d   = gnt_any & sel_bad;
        resp_rd_d    = gnt_any & ~sel_bad & ~sel_we;
        case (state_q)
            ST_ARB:  if (gnt1 && p1_lock_i && !force_rel) state_d = ST_LOCK;
            ST_LOCK: if (!p1_lock_i || force_rel)          state_d = ST_ARB;
            default: state_d = ST_ARB;
        endcase
    end

    // rr_last resets to 1 so that port 0 wins the first contended cycle.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= ST_ARB;
            rr_last_q    <= 1'b1;
            lock_cnt_q   <= '0;
            resp_pend_q  <= 1'b0;
            resp_owner_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rd_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_last_q    <= rr_last_d;
            lock_cnt_q   <= lock_cnt_d;
            resp_pend_q  <= resp_pend_d;
            resp_owner_q <= resp_owner_d;
            resp_err_q   <= resp_err_d;
            resp_rd_q    <= resp_rd_d;
        end
    end

    assign p0_rvalid_o = resp_pend_q & ~resp_owner_q;
    assign p1_rvalid_o = resp_pend_q &  resp_owner_q;
    assign p0_err_o    = resp_err_q  & ~resp_owner_q;
    assign p1_err_o    = resp_err_q  &  resp_owner_q;
    assign p0_rdata_o  = (resp_rd_q && !resp_owner_q) ? mem_rdata_i : '0;
    assign p1_rdata_o  = (resp_rd_q &&  resp_owner_q) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios then random traffic against a transaction-level model.
module tb_dmem_port_arbiter;
    localparam int XLEN = 32, ADDR_W = 11, LOCK_MAX = 4, DEPTH = 1 << ADDR_W;

    logic clk_i, rstn_i;
    logic p0_valid_i, p0_ready_o, p0_we_i, p0_rvalid_o, p0_err_o;
    logic p1_valid_i, p1_ready_o, p1_we_i, p1_rvalid_o, p1_err_o, p1_lock_i;
    logic [3:0] p0_be_i, p1_be_i, mem_be_o;
    logic [XLEN-1:0] p0_addr_i, p0_wdata_i, p0_rdata_o, p1_addr_i, p1_wdata_i, p1_rdata_o;
    logic stall_o, mem_req_o, mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [XLEN-1:0] mem_wdata_o, mem_rdata_i;

    dmem_port_arbiter #(.XLEN(XLEN), .ADDR_W(ADDR_W), .LOCK_MAX(LOCK_MAX)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .p0_valid_i(p0_valid_i), .p0_ready_o(p0_ready_o), .p0_we_i(p0_we_i), .p0_be_i(p0_be_i),
        .p0_addr_i(p0_addr_i), .p0_wdata_i(p0_wdata_i), .p0_rvalid_o(p0_rvalid_o),
        .p0_rdata_o(p0_rdata_o), .p0_err_o(p0_err_o),
        .p1_valid_i(p1_valid_i), .p1_ready_o(p1_ready_o), .p1_we_i(p1_we_i), .p1_be_i(p1_be_i),
        .p1_addr_i(p1_addr_i), .p1_wdata_i(p1_wdata_i), .p1_rvalid_o(p1_rvalid_o),
        .p1_rdata_o(p1_rdata_o), .p1_err_o(p1_err_o), .p1_lock_i(p1_lock_i),
        .stall_o(stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Environment memory: synchronous SRAM with one-cycle read latency.
    logic [XLEN-1:0] mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        mem_rdata_i <= '0;
        forever begin
            @(posedge clk_i);
            if (mem_req_o) begin
                if (mem_we_o) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_be_o[b]) mem[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
                end else begin
                    mem_rdata_i <= mem[mem_addr_o];
                end
            end
        end
    end

    int n_checks = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Requester state and reference model
    logic        rv [2];
    logic        rwe [2];
    logic [3:0]  rbe [2];
    logic [31:0] ra [2], rwd [2];
    logic        rlk;
    int          burst;
    logic [31:0] ref_mem [DEPTH];
    logic [3:0]  legal_be [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    logic [3:0]  bad_be [4]   = '{4'b0000, 4'b0101, 4'b0110, 4'b1110};
    bit          m_pref0, m_locked;
    int          m_beats, last_g;
    bit          er_v, er_err;
    int          er_own;
    logic [31:0] er_dat;

    function automatic bit is_bad(input logic [3:0] be, input logic [31:0] a);
        bit ok = 0;
        for (int i = 0; i < 7; i++) if (legal_be[i] == be) ok = 1;
        return !ok || (a % 4 != 0) || ((a / 4) >= DEPTH);
    endfunction

    task automatic model_reset();
        m_pref0 = 1; m_locked = 0; m_beats = 0; er_v = 0; er_own = 0; er_err = 0; er_dat = '0;
        rv[0] = 0; rv[1] = 0; rlk = 0; burst = 0; last_g = -1;
    endtask

    task automatic drive();
        p0_valid_i = rv[0]; p0_we_i = rwe[0]; p0_be_i = rbe[0]; p0_addr_i = ra[0]; p0_wdata_i = rwd[0];
        p1_valid_i = rv[1]; p1_we_i = rwe[1]; p1_be_i = rbe[1]; p1_addr_i = ra[1]; p1_wdata_i = rwd[1];
        p1_lock_i = rv[1] && rlk;
    endtask

    task automatic set_req(input int p, input bit we, input logic [3:0] be, input logic [31:0] a,
                           input logic [31:0] d, input bit lk);
        rv[p] = 1; rwe[p] = we; rbe[p] = be; ra[p] = a; rwd[p] = d;
        if (p == 1) rlk = lk;
    endtask

    task automatic rand_req(input int p, input bit lk);
        int k = $urandom_range(0, 19);
        logic [31:0] a = 32'($urandom_range(0, 15)) << 2;
        logic [3:0] be = legal_be[$urandom_range(0, 6)];
        if (k == 16) a = a | 32'($urandom_range(1, 3));
        else if (k == 17) a = 32'h2000 + a;
        else if (k >= 18) be = bad_be[$urandom_range(0, 3)];
        set_req(p, 1'($urandom_range(0, 1)), be, a, $urandom, lk);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_p0_ready"}, 32'(p0_ready_o), 0);
        chk({tag, "_p1_ready"}, 32'(p1_ready_o), 0);
        chk({tag, "_rvalid"}, {30'b0, p1_rvalid_o, p0_rvalid_o}, 0);
        chk({tag, "_err"}, {30'b0, p1_err_o, p0_err_o}, 0);
        chk({tag, "_p0_rdata"}, p0_rdata_o, 0);
        chk({tag, "_p1_rdata"}, p1_rdata_o, 0);
        chk({tag, "_mem_req"}, 32'(mem_req_o), 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr_o), 0);
        chk({tag, "_stall"}, 32'(stall_o), 0);
    endtask

    // One clock: drive, check last cycle's response and this cycle's grant, advance the model.
    task automatic cycle();
        int g;
        bit e, lock_in;
        int w;
        @(negedge clk_i);
        drive();
        #1;
        chk("p0_rvalid", 32'(p0_rvalid_o), 32'(er_v && er_own == 0));
        chk("p1_rvalid", 32'(p1_rvalid_o), 32'(er_v && er_own == 1));
        chk("p0_err", 32'(p0_err_o), 32'(er_v && er_own == 0 && er_err));
        chk("p1_err", 32'(p1_err_o), 32'(er_v && er_own == 1 && er_err));
        chk("p0_rdata", p0_rdata_o, (er_v && er_own == 0) ? er_dat : 32'h0);
        chk("p1_rdata", p1_rdata_o, (er_v && er_own == 1) ? er_dat : 32'h0);

        g = -1;
        if (!m_locked) begin
            if (rv[0] && rv[1]) g = m_pref0 ? 0 : 1;
            else if (rv[0]) g = 0;
            else if (rv[1]) g = 1;
        end else if (rv[1] && !(m_beats >= LOCK_MAX && rv[0])) begin
            g = 1;
        end
        chk("p0_ready", 32'(p0_ready_o), 32'(g == 0));
        chk("p1_ready", 32'(p1_ready_o), 32'(g == 1));
        chk("stall", 32'(stall_o), 32'(rv[0] && g != 0));

        e = 0;
        er_v = (g >= 0);
        if (g >= 0) begin
            e = is_bad(rbe[g], ra[g]);
            w = int'(ra[g] / 4);
            er_own = g; er_err = e;
            er_dat = (e || rwe[g]) ? 32'h0 : ref_mem[w];
            if (!e) begin
                chk("mem_we", 32'(mem_we_o), 32'(rwe[g]));
                chk("mem_addr", 32'(mem_addr_o), 32'(w));
                chk("mem_be", 32'(mem_be_o), 32'(rbe[g]));
                if (rwe[g]) begin
                    chk("mem_wdata", mem_wdata_o, rwd[g]);
                    for (int b = 0; b < 4; b++) if (rbe[g][b]) ref_mem[w][8*b +: 8] = rwd[g][8*b +: 8];
                end
            end
        end
        chk("mem_req", 32'(mem_req_o), 32'(g >= 0 && !e));

        lock_in = rv[1] && rlk;
        if (g >= 0) m_pref0 = (g == 1);
        if (g == 1) m_beats = m_locked ? m_beats + 1 : 1;
        if (!m_locked && g == 1 && lock_in) m_locked = 1;
        if (m_locked && (!lock_in || (m_beats >= LOCK_MAX && rv[0]))) m_locked = 0;
        last_g = g;
        @(posedge clk_i);
        if (g >= 0) rv[g] = 0;
        if (g == 1 && burst > 0) burst--;
    endtask

    initial begin
        int n_run;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        for (int p = 0; p < 2; p++) begin rwe[p] = 0; rbe[p] = 0; ra[p] = 0; rwd[p] = 0; end
        model_reset();
        rstn_i = 1'b0;
        drive();
        #3 chk_quiet("reset");
        @(negedge clk_i); @(negedge clk_i);
        #2 rstn_i = 1'b1;

        // Loader writes a word, pipeline reads it back
        set_req(1, 1, 4'hF, 32'h10, 32'hDEADBEEF, 0); cycle();
        set_req(0, 0, 4'hF, 32'h10, 32'h0, 0);        cycle();
        cycle();
        // Port 1 write then immediate read of the same word
        set_req(1, 1, 4'hF, 32'h20, 32'h12345678, 0); cycle();
        set_req(1, 0, 4'hF, 32'h20, 32'h0, 0);        cycle();
        cycle();

        // Continuous contention alternates, starting with port 0
        for (int i = 0; i < 6; i++) begin
            if (!rv[0]) set_req(0, 0, 4'hF, 32'h10, 32'h0, 0);
            if (!rv[1]) set_req(1, 0, 4'hF, 32'h20, 32'h0, 0);
            cycle();
            chk("rr_alt", 32'(last_g), 32'(i % 2));
        end
        cycle();

        // Misaligned request errors without touching memory; next one proceeds
        set_req(0, 0, 4'hF, 32'h2, 32'h0, 0);  cycle();
        set_req(0, 0, 4'hF, 32'h10, 32'h0, 0); cycle();
        cycle();

        // Locked port-1 burst against a waiting port 0
        set_req(0, 0, 4'hF, 32'h20, 32'h0, 0);
        n_run = 0;
        for (int i = 0; i < 5; i++) begin
            if (!rv[1]) set_req(1, 1, 4'hF, 32'h30 + 32'(4 * i), $urandom, 1);
            cycle();
            if (i < 4 && last_g == 1) n_run++;
        end
        chk("lock_run", 32'(n_run), 32'(LOCK_MAX));
        chk("lock_release_p0", 32'(last_g), 0);
        rv[1] = 0; rlk = 0;
        cycle(); cycle();

        // Random traffic with occasional locked bursts
        for (int c = 0; c < 600; c++) begin
            if (!rv[0] && $urandom_range(0, 99) < 55) rand_req(0, 0);
            if (!rv[1]) begin
                if (burst > 0) rand_req(1, burst > 1);
                else if ($urandom_range(0, 99) < 40) begin
                    burst = ($urandom_range(0, 99) < 30) ? $urandom_range(2, 7) : 0;
                    rand_req(1, burst > 1);
                end
            end
            cycle();
        end
        burst = 0;

        // Asynchronous reset in the middle of an access
        if (!rv[0]) set_req(0, 0, 4'hF, 32'h10, 32'h0, 0);
        if (!rv[1]) set_req(1, 0, 4'hF, 32'h20, 32'h0, 0);
        rlk = 0;
        cycle();
        #2 rstn_i = 1'b0;
        #1 chk_quiet("arst");
        model_reset();
        @(negedge clk_i); drive();
        @(posedge clk_i); #2 rstn_i = 1'b1;
        set_req(0, 0, 4'hF, 32'h10, 32'h0, 0);
        set_req(1, 0, 4'hF, 32'h20, 32'h0, 0);
        cycle();
        chk("post_rst_first_grant", 32'(last_g), 0);
        cycle(); cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
